// File: rtl/sync_fifo_pkg.sv
// Shared sizing helpers and parameter legality checks for sync_fifo_flags.
package sync_fifo_pkg;

    function automatic int cnt_width(input int addr_width);
        return addr_width + 1;
    endfunction

    function automatic int fifo_depth(input int addr_width);
        return 1 << addr_width;
    endfunction

    // almost_full must be reachable and nonzero; almost_empty must be able to deassert.
    function automatic bit thresh_legal(input int addr_width, input int afull, input int aempty);
        int depth;
        depth = fifo_depth(addr_width);
        return (afull >= 1) && (afull <= depth) && (aempty >= 0) && (aempty <= depth - 1);
    endfunction

endpackage

// File: rtl/fifo_ram_dp.sv
// Simple dual-port RAM: synchronous write, registered read (combinational read when
// SYNC_FIFO_FWFT_EN is defined).
module fifo_ram_dp
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int DEPTH = fifo_depth(ADDR_WIDTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    assign rdata = mem[raddr];
`else
    // Output register resets so dout reads zero out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end
`endif

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, almost flags and sticky error flags.
// Define SYNC_FIFO_FWFT_EN for first-word fall-through reads.
module sync_fifo_flags
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 4,
    parameter int AFULL_THRESH  = 12,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  wr_en,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  clr_err
);

    localparam int CW    = cnt_width(ADDR_WIDTH);
    localparam int DEPTH = fifo_depth(ADDR_WIDTH);
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_THRESH);
    localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_THRESH);

    if (!thresh_legal(ADDR_WIDTH, AFULL_THRESH, AEMPTY_THRESH)) begin : g_bad_thresh
        $error("sync_fifo_flags: illegal almost-full/almost-empty threshold");
    end

    logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0]         count_q, count_nxt;
    logic                  full_q, empty_q, afull_q, aempty_q;
    logic                  ovf_q, unf_q, valid_q;
    logic                  push_ok, pop_ok;
    logic [DATA_WIDTH-1:0] ram_rdata;

    always_comb begin
        push_ok   = wr_en && !full_q;
        pop_ok    = rd_en && !empty_q;
        count_nxt = count_q;
        if (push_ok && !pop_ok) begin
            count_nxt = count_q + CW'(1);
        end else if (pop_ok && !push_ok) begin
            count_nxt = count_q - CW'(1);
        end
    end

    // Flags are registered from count_nxt so they change on the same edge as count.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count_q  <= count_nxt;
            full_q   <= (count_nxt == DEPTH_C);
            empty_q  <= (count_nxt == '0);
            afull_q  <= (count_nxt >= AFULL_C);
            aempty_q <= (count_nxt <= AEMPTY_C);
            valid_q  <= pop_ok;
            // clr_err wins over a same-cycle error event.
            if (clr_err) begin
                ovf_q <= 1'b0;
                unf_q <= 1'b0;
            end else begin
                ovf_q <= ovf_q | (wr_en && full_q);
                unf_q <= unf_q | (rd_en && empty_q);
            end
        end
    end

    fifo_ram_dp #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (push_ok),
        .waddr (wr_ptr),
        .wdata (din),
        .re    (pop_ok),
        .raddr (rd_ptr),
        .rdata (ram_rdata)
    );

`ifdef SYNC_FIFO_FWFT_EN
    assign dout       = empty_q ? '0 : ram_rdata;
    assign dout_valid = !empty_q;
`else
    assign dout       = ram_rdata;
    assign dout_valid = valid_q;
`endif

    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = afull_q;
    assign almost_empty = aempty_q;
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

endmodule
